// File: rtl/scroll_display_ctrl_if.sv
// Host-side bundle for scroll_display_ctrl: load request, source data, blanking,
// busy status and the segment panel.
interface scroll_display_ctrl_if #(
   parameter int unsigned DATA_W       = 10,
   parameter int unsigned NUM_SRC      = 2,
   parameter int unsigned PANEL_DIGITS = 2
);
   localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic                        load;
   logic [1:0]                  mode;
   logic [SEL_W-1:0]            sel;
   logic [NUM_SRC*DATA_W-1:0]   data_in;
   logic                        blank;
   logic                        busy;
   logic [PANEL_DIGITS*9-1:0]   seg;

   modport master (
      output load, mode, sel, data_in, blank,
      input  busy, seg
   );

   modport slave (
      input  load, mode, sel, data_in, blank,
      output busy, seg
   );
endinterface

// File: rtl/scroll_display_ctrl.sv
// Multi-channel seven-segment controller: captures a source value (or min/max), converts it
// to BCD by double-dabble, and shows it right-aligned or as a circular scroll.
module scroll_display_ctrl #(
   parameter int unsigned DATA_W       = 10,
   parameter int unsigned NUM_SRC      = 2,
   parameter int unsigned BCD_DIGITS   = 4,
   parameter int unsigned PANEL_DIGITS = 2,
   parameter int unsigned SCROLL_DIV   = 25_000_000
) (
   input logic                   clk,
   input logic                   rst,
   scroll_display_ctrl_if.slave  bus_if
);

   localparam int unsigned NW = $clog2(BCD_DIGITS + 1);
   localparam int unsigned CW = $clog2(DATA_W + 1);
   localparam int unsigned PW = $clog2(SCROLL_DIV);
   localparam int unsigned BW = BCD_DIGITS * 4;
   localparam logic [8:0]  BlankCode = 9'h100;

   typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

   state_e                  state_q;
   logic                    busy_q;
   logic [DATA_W-1:0]       bin_q;
   logic [BW-1:0]           bcd_q;
   logic [CW-1:0]           cnt_q;
   logic [BW-1:0]           disp_q;
   logic [NW-1:0]           ndig_q;
   logic                    valid_q;
   logic [NW-1:0]           offset_q;
   logic [PW-1:0]           presc_q;

   logic [DATA_W-1:0]       chan [NUM_SRC];
   logic [DATA_W-1:0]       cap_val;
   logic [BW-1:0]           bcd_adj;
   logic [BW-1:0]           bcd_shift;
   logic [NW-1:0]           ndig_new;
   logic                    scroll_mode;
   logic [PANEL_DIGITS*9-1:0] seg_c;
   int                      k;

   function automatic logic [8:0] seg_code(input logic [3:0] d);
      logic [8:0] code;
      case (d)
         4'd0:    code = 9'h03F;
         4'd1:    code = 9'h006;
         4'd2:    code = 9'h05B;
         4'd3:    code = 9'h04F;
         4'd4:    code = 9'h066;
         4'd5:    code = 9'h06D;
         4'd6:    code = 9'h07D;
         4'd7:    code = 9'h007;
         4'd8:    code = 9'h07F;
         4'd9:    code = 9'h06F;
         default: code = BlankCode;
      endcase
      return code;
   endfunction

   always_comb begin
      for (int c = 0; c < NUM_SRC; c++) begin
         chan[c] = bus_if.data_in[c*DATA_W +: DATA_W];
      end
   end

   // Strict compares keep the lowest-index channel on ties.
   always_comb begin
      cap_val = chan[0];
      case (bus_if.mode)
         2'd1: begin
            for (int c = 1; c < NUM_SRC; c++) begin
               if (chan[c] < cap_val) cap_val = chan[c];
            end
         end
         2'd2: begin
            for (int c = 1; c < NUM_SRC; c++) begin
               if (chan[c] > cap_val) cap_val = chan[c];
            end
         end
         default: begin
            for (int c = 1; c < NUM_SRC; c++) begin
               if (int'(bus_if.sel) == c) cap_val = chan[c];
            end
         end
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd_q[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
   end

   always_comb begin
      ndig_new = NW'(1);
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd_q[d*4 +: 4] != 4'd0) ndig_new = NW'(d + 1);
      end
   end

   assign scroll_mode = valid_q && (int'(ndig_q) > PANEL_DIGITS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         disp_q   <= '0;
         ndig_q   <= NW'(1);
         valid_q  <= 1'b0;
         offset_q <= '0;
         presc_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_if.load) begin
                  bin_q   <= cap_val;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StConv;
               end else if (scroll_mode) begin
                  // Offset cycles through N digits plus one trailing blank.
                  if (presc_q == PW'(SCROLL_DIV - 1)) begin
                     presc_q  <= '0;
                     offset_q <= (offset_q == ndig_q) ? '0 : offset_q + NW'(1);
                  end else begin
                     presc_q <= presc_q + PW'(1);
                  end
               end
            end
            StConv: begin
               bcd_q <= bcd_shift;
               bin_q <= bin_q << 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_W - 1)) state_q <= StCommit;
            end
            StCommit: begin
               disp_q   <= bcd_q;
               ndig_q   <= ndig_new;
               valid_q  <= 1'b1;
               offset_q <= '0;
               presc_q  <= '0;
               busy_q   <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Position PANEL_DIGITS-1-p shows frame[(offset + i) mod (N+1)], frame = d[N-1]..d[0], blank.
   always_comb begin
      k     = 0;
      seg_c = {PANEL_DIGITS{BlankCode}};
      if (valid_q && !bus_if.blank) begin
         for (int p = 0; p < PANEL_DIGITS; p++) begin
            if (!scroll_mode) begin
               if (p < int'(ndig_q)) seg_c[p*9 +: 9] = seg_code(disp_q[p*4 +: 4]);
            end else begin
               k = int'(offset_q) + int'(PANEL_DIGITS) - 1 - p;
               if (k > int'(ndig_q)) k = k - int'(ndig_q) - 1;
               if (k < int'(ndig_q)) begin
                  seg_c[p*9 +: 9] = seg_code(disp_q[(int'(ndig_q) - 1 - k)*4 +: 4]);
               end
            end
         end
      end
   end

   assign bus_if.seg  = seg_c;
   assign bus_if.busy = busy_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed bench for scroll_display_ctrl: 4 channels, 2-digit panel, 4-cycle scroll step.
module tb_scroll_display_ctrl;

   localparam int unsigned DW  = 10;
   localparam int unsigned NS  = 4;
   localparam int unsigned PD  = 2;
   localparam int unsigned DIV = 4;

   localparam logic [8:0] B  = 9'h100;
   localparam logic [8:0] S0 = 9'h03F;
   localparam logic [8:0] S1 = 9'h006;
   localparam logic [8:0] S2 = 9'h05B;
   localparam logic [8:0] S3 = 9'h04F;
   localparam logic [8:0] S5 = 9'h06D;
   localparam logic [8:0] S7 = 9'h007;
   localparam logic [8:0] S8 = 9'h07F;
   localparam logic [8:0] S9 = 9'h06F;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   scroll_display_ctrl_if #(.DATA_W(DW), .NUM_SRC(NS), .PANEL_DIGITS(PD)) bus ();

   scroll_display_ctrl #(
      .DATA_W      (DW),
      .NUM_SRC     (NS),
      .BCD_DIGITS  (4),
      .PANEL_DIGITS(PD),
      .SCROLL_DIV  (DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [DW-1:0] val);
      bus.data_in[ch*DW +: DW] = val;
   endtask

   task automatic do_load(input logic [1:0] m, input logic [1:0] s);
      bus.mode = m;
      bus.sel  = s;
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   logic [17:0] f123  [4] = '{{S1, S2}, {S2, S3}, {S3, B}, {B, S1}};
   logic [17:0] f900  [4] = '{{S9, S0}, {S0, S0}, {S0, B}, {B, S9}};
   logic [17:0] f1023 [5] = '{{S1, S0}, {S0, S2}, {S2, S3}, {S3, B}, {B, S1}};

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      bus.load    = 1'b0;
      bus.mode    = 2'd0;
      bus.sel     = '0;
      bus.data_in = '0;
      bus.blank   = 1'b0;

      // Reset and idle-without-load.
      tick();
      tick();
      check("reset_seg", bus.seg, {B, B});
      check("reset_busy", {17'd0, bus.busy}, 18'd0);
      rst = 1'b0;
      repeat (20) tick();
      check("idle_seg", bus.seg, {B, B});
      check("idle_busy", {17'd0, bus.busy}, 18'd0);

      // SELECT channel 1 = 7: busy for 11 cycles, then static "_7".
      set_ch(0, 10'd500);
      set_ch(1, 10'd7);
      set_ch(2, 10'd37);
      set_ch(3, 10'd900);
      do_load(2'd0, 2'd1);
      for (int c = 0; c < 11; c++) begin
         check("sel7_busy", {17'd0, bus.busy}, 18'd1);
         check("sel7_hold", bus.seg, {B, B});
         tick();
      end
      check("sel7_done", {17'd0, bus.busy}, 18'd0);
      check("sel7_seg", bus.seg, {B, S7});
      repeat (3 * DIV) tick();
      check("sel7_static", bus.seg, {B, S7});

      // Value 0 shows a single "0".
      set_ch(0, 10'd0);
      do_load(2'd0, 2'd0);
      repeat (11) tick();
      check("zero_seg", bus.seg, {B, S0});

      // Scroll 123 with each frame held DIV cycles.
      set_ch(0, 10'd123);
      do_load(2'd0, 2'd0);
      repeat (11) tick();
      for (int f = 0; f < 5; f++) begin
         for (int c = 0; c < int'(DIV); c++) begin
            check("scroll123", bus.seg, f123[f % 4]);
            tick();
         end
      end

      // MIN over {500,37,37,900}, then MAX accepted on the first edge after busy falls.
      set_ch(0, 10'd500);
      set_ch(1, 10'd37);
      do_load(2'd1, 2'd0);
      repeat (11) tick();
      check("min_busy", {17'd0, bus.busy}, 18'd0);
      check("min_seg", bus.seg, {S3, S7});
      do_load(2'd2, 2'd0);
      check("max_accept", {17'd0, bus.busy}, 18'd1);
      repeat (11) tick();
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < int'(DIV); c++) begin
            check("max900", bus.seg, f900[f]);
            tick();
         end
      end

      // 1023, with a second load of 5 two cycles later that must be ignored.
      set_ch(0, 10'd1023);
      do_load(2'd0, 2'd0);
      tick();
      set_ch(0, 10'd5);
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      check("ign_busy", {17'd0, bus.busy}, 18'd1);
      repeat (9) tick();
      check("ign_done", {17'd0, bus.busy}, 18'd0);
      for (int f = 0; f < 5; f++) begin
         for (int c = 0; c < int'(DIV); c++) begin
            bus.blank = (f == 2) && (c == 1 || c == 2);
            #1;
            if (bus.blank) check("blank_pulse", bus.seg, {B, B});
            else check("scroll1023", bus.seg, f1023[f]);
            @(posedge clk);
            #1;
         end
      end
      bus.blank = 1'b0;
      #1;
      check("scroll1023_wrap", bus.seg, f1023[0]);
      check("ign_still_idle", {17'd0, bus.busy}, 18'd0);

      // Reset on CONV step 5 aborts; a fresh load of 58 takes exactly 11 cycles.
      set_ch(0, 10'd42);
      do_load(2'd0, 2'd0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", {17'd0, bus.busy}, 18'd0);
      check("abort_seg", bus.seg, {B, B});
      set_ch(0, 10'd58);
      do_load(2'd0, 2'd0);
      check("reload_busy", {17'd0, bus.busy}, 18'd1);
      repeat (10) tick();
      check("reload_latency_busy", {17'd0, bus.busy}, 18'd1);
      check("reload_latency_seg", bus.seg, {B, B});
      tick();
      check("reload_busy_done", {17'd0, bus.busy}, 18'd0);
      check("reload_seg", bus.seg, {S5, S8});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
